counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples required to accept a button level change; legal range 1..255.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset; synchronous, active-low; sampled on rising Clk.
REQ-004 Push  input  2  active-low push buttons, 1 = released; Push[1] = UP, Push[0] = DOWN; asynchronous to Clk, may bounce.
REQ-005 Cnt_o_LED  output  4  registered binary count, range 0..9, drives LEDs.
REQ-006 Seg_o  output  7  registered seven-segment image of the count, bit order {g,f,e,d,c,b,a}, active-low (0 = segment lit).

Function
REQ-007 Each Push bit SHALL pass through its own 2-flop synchronizer before any other use.
REQ-008 Each synchronized bit SHALL feed a debouncer holding a debounced level D (reset value 1) and a counter.
REQ-009 D SHALL take the synchronized value only after that value has differed from D on DEBOUNCE_CYCLES consecutive clocks; any sample equal to D clears the counter.
REQ-010 A press event SHALL be a single-cycle pulse generated on the clock after D goes 1->0; release (0->1) generates no event.
REQ-011 A held button SHALL yield exactly one event per press regardless of hold length; there is no auto-repeat.
REQ-012 On an UP event alone: count = count+1, with 9 wrapping to 0.
REQ-013 On a DOWN event alone: count = count-1, with 0 wrapping to 9.
REQ-014 If UP and DOWN events occur in the same cycle, the count SHALL be unchanged.
REQ-015 Latency: the count SHALL change on the (2 + DEBOUNCE_CYCLES + 1)th rising edge after a stable Push change, i.e. 7 edges at the default.
REQ-016 Pulses shorter than DEBOUNCE_CYCLES clocks, measured after synchronization, SHALL be ignored.
REQ-017 Cnt_o_LED SHALL equal the count register directly; the count SHALL never hold a value above 9.
REQ-018 Seg_o SHALL be registered and update on the same edge as Cnt_o_LED, with patterns:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- any other value = 1111111 (blank, defensive)
REQ-019 The two button paths SHALL be fully independent; each has its own synchronizer and debouncer.

Reset
REQ-020 While Rst=0 at a rising edge:
- count = 0, Cnt_o_LED = 0000, Seg_o = 1000000
- synchronizer flops = 1, D = 1, debounce counters = 0, no event pulse
REQ-021 A button held low across reset deassertion SHALL produce exactly one event, DEBOUNCE_CYCLES+2 clocks after synchronous release of reset.
REQ-022 A reset asserted mid-debounce SHALL discard the partial count; no event is generated from it.

Verification
REQ-023 Reset, Push=11, idle 20 clocks -> Cnt_o_LED=0, Seg_o=1000000, no change.
REQ-024 Nine UP presses (Push=01 for 10 clocks, then 11 for 10 clocks) -> counts 1..9 in order; final Cnt_o_LED=9, Seg_o=0010000; exactly one step per press.
REQ-025 From 9: one UP -> 0. From 0: one DOWN -> 9. Eight DOWN presses from 9 -> 1.
REQ-026 Bounce: UP toggling every clock for 10 clocks, then stable low for 10 -> single increment; 3-clock glitch -> no change.
REQ-027 Push=00 pressed simultaneously -> count unchanged; reset asserted with count=5 -> count 0 on the next edge.

Source files
------------

// File: rtl/counter.sv
// Debounced up/down push-button counter, 0..9 with wrap, driving a binary LED
// bus and an active-low seven-segment display.

module counter_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Synchronizer, debounced level, run counter and press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // A sample equal to the debounced level restarts the run count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

module counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Push,
  output logic [3:0] Cnt_o_LED,
  output logic [6:0] Seg_o
);

  localparam int unsigned COUNT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(9);

  logic                up_press;
  logic                dn_press;
  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  count_d;
  logic [SEG_W-1:0]    seg_q;
  logic [SEG_W-1:0]    seg_d;

  counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (Clk),
    .rst_n   (Rst),
    .btn_raw (Push[1]),
    .press   (up_press)
  );

  counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk     (Clk),
    .rst_n   (Rst),
    .btn_raw (Push[0]),
    .press   (dn_press)
  );

  // Segment image {g,f,e,d,c,b,a}, active-low; out-of-range values blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [COUNT_W-1:0] v);
    logic [SEG_W-1:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Simultaneous up and down presses cancel.
  always_comb begin
    count_d = count_q;
    if (up_press && !dn_press) begin
      count_d = (count_q >= COUNT_MAX) ? '0 : count_q + COUNT_W'(1);
    end else if (dn_press && !up_press) begin
      count_d = (count_q == '0 || count_q > COUNT_MAX) ? COUNT_MAX : count_q - COUNT_W'(1);
    end
    seg_d = seg_decode(count_d);
  end

  // Segment image is registered alongside the count so both move on one edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q <= '0;
      seg_q   <= 7'b1000000;
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
    end
  end

  assign Cnt_o_LED = count_q;
  assign Seg_o     = seg_q;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: directed scenarios plus random button activity, checked
// cycle by cycle against a run-length model of the debounced buttons.

module tb_counter;

  localparam int unsigned N = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] Push;
  logic [3:0] Cnt_o_LED;
  logic [6:0] Seg_o;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Model state: count, pending press events, debounced level, current run.
  int         m_cnt;
  logic [1:0] m_pend;
  logic [1:0] m_lvl;
  logic [1:0] m_last;
  int         m_run [2];
  logic [1:0] m_hist [$];

  always #5 Clk = ~Clk;

  counter #(.DEBOUNCE_CYCLES(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Push      (Push),
    .Cnt_o_LED (Cnt_o_LED),
    .Seg_o     (Seg_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge(input logic [1:0] p, input logic r);
    logic [1:0] v;
    if (!r) begin
      m_cnt  = 0;
      m_pend = 2'b00;
      m_lvl  = 2'b11;
      m_last = 2'b11;
      m_run[0] = 0;
      m_run[1] = 0;
      m_hist.delete();
    end else begin
      // Two-stage synchronization: the debouncer sees the sample from two edges ago.
      if (m_hist.size() >= 2) v = m_hist.pop_front();
      else v = 2'b11;
      m_hist.push_back(p);
      if (m_pend == 2'b10) m_cnt = (m_cnt + 1) % 10;
      else if (m_pend == 2'b01) m_cnt = (m_cnt + 9) % 10;
      m_pend = 2'b00;
      for (int b = 0; b < 2; b++) begin
        if (v[b] == m_last[b]) m_run[b]++;
        else begin
          m_last[b] = v[b];
          m_run[b]  = 1;
        end
        if (v[b] != m_lvl[b] && m_run[b] >= N) begin
          m_lvl[b] = v[b];
          if (v[b] == 1'b0) m_pend[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input logic [1:0] p, input logic r);
    Push = p;
    Rst  = r;
    @(posedge Clk);
    model_edge(p, r);
    @(negedge Clk);
    check_eq("cnt_model", 32'(Cnt_o_LED), 32'(m_cnt));
    check_eq("seg_model", 32'(Seg_o), 32'(seg_tab[m_cnt]));
  endtask

  task automatic press(input logic [1:0] p, input int hold, input int rel);
    repeat (hold) tick(p, 1'b1);
    repeat (rel) tick(2'b11, 1'b1);
  endtask

  initial begin
    Push = 2'b11;
    Rst  = 1'b0;
    repeat (3) tick(2'b11, 1'b0);
    check_eq("reset_cnt", 32'(Cnt_o_LED), 32'd0);
    check_eq("reset_seg", 32'(Seg_o), 32'b1000000);

    repeat (20) tick(2'b11, 1'b1);
    check_eq("idle_cnt", 32'(Cnt_o_LED), 32'd0);
    check_eq("idle_seg", 32'(Seg_o), 32'b1000000);

    for (int i = 1; i <= 9; i++) begin
      press(2'b01, 10, 10);
      check_eq("up_seq", 32'(Cnt_o_LED), 32'(i));
    end
    check_eq("nine_seg", 32'(Seg_o), 32'b0010000);

    press(2'b01, 10, 10);
    check_eq("wrap_up", 32'(Cnt_o_LED), 32'd0);
    press(2'b10, 10, 10);
    check_eq("wrap_dn", 32'(Cnt_o_LED), 32'd9);
    for (int i = 0; i < 8; i++) press(2'b10, 10, 10);
    check_eq("eight_dn", 32'(Cnt_o_LED), 32'd1);

    for (int i = 0; i < 10; i++) tick((i % 2 == 0) ? 2'b01 : 2'b11, 1'b1);
    press(2'b01, 10, 10);
    check_eq("bounce", 32'(Cnt_o_LED), 32'd2);

    press(2'b01, 3, 10);
    check_eq("glitch3", 32'(Cnt_o_LED), 32'd2);
    press(2'b10, 1, 10);
    check_eq("glitch1", 32'(Cnt_o_LED), 32'd2);

    press(2'b00, 10, 10);
    check_eq("both", 32'(Cnt_o_LED), 32'd2);

    // Exact latency: unchanged after 6 edges, stepped on the 7th.
    repeat (6) tick(2'b01, 1'b1);
    check_eq("lat_before", 32'(Cnt_o_LED), 32'd2);
    tick(2'b01, 1'b1);
    check_eq("lat_after", 32'(Cnt_o_LED), 32'd3);
    repeat (30) tick(2'b01, 1'b1);
    check_eq("no_repeat", 32'(Cnt_o_LED), 32'd3);
    repeat (10) tick(2'b11, 1'b1);

    press(2'b01, 10, 10);
    press(2'b01, 10, 10);
    check_eq("at_five", 32'(Cnt_o_LED), 32'd5);
    tick(2'b11, 1'b0);
    check_eq("reset_five", 32'(Cnt_o_LED), 32'd0);
    check_eq("reset_five_seg", 32'(Seg_o), 32'b1000000);

    repeat (4) tick(2'b01, 1'b1);
    tick(2'b11, 1'b0);
    repeat (15) tick(2'b11, 1'b1);
    check_eq("mid_reset", 32'(Cnt_o_LED), 32'd0);

    repeat (2) tick(2'b01, 1'b0);
    repeat (6) tick(2'b01, 1'b1);
    check_eq("held_rst_before", 32'(Cnt_o_LED), 32'd0);
    tick(2'b01, 1'b1);
    check_eq("held_rst_after", 32'(Cnt_o_LED), 32'd1);
    repeat (20) tick(2'b01, 1'b1);
    check_eq("held_rst_once", 32'(Cnt_o_LED), 32'd1);
    repeat (10) tick(2'b11, 1'b1);

    for (int s = 0; s < 400; s++) begin
      logic [1:0] p;
      int len;
      logic r;
      p   = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      r   = ($urandom_range(0, 49) != 0);
      repeat (len) tick(p, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
